flash_arb: RTL and testbench
============================

FLASH_ARB -- requirements
Module: flash_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one bound flasher.
REQ-002 Parameter MX_LP, default 16: lamp bus width.
REQ-003 Parameter TMO_CYC, default 255: watchdog limit in clk cycles per session.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-high (asserted = 1).
REQ-006 req  input  N_REQ  per-requester session request, level.
REQ-007 ext  input  N_REQ  per-requester kickback request, level; only the granted bit is used.
REQ-008 fl_lamp  input  MX_LP  lamp bus from the flasher.
REQ-009 fl_nstate  input  3  flasher next-state (INIT=3'b000).
REQ-010 flick  output  1  flick drive to the flasher, registered.
REQ-011 gnt  output  N_REQ  one-hot grant, registered, held for the whole session.
REQ-012 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky watchdog flag.

Function
REQ-015 FSM states: IDLE, START, RUN, DONE.
REQ-016 IDLE: if req != 0, grant the first set bit at or after round-robin pointer ptr (wrapping); register gnt; go to START next edge. Otherwise stay, gnt=0.
REQ-017 START: flick=1 for exactly one cycle; go to RUN.
REQ-018 RUN: flick = ext[granted index], registered, so one cycle of latency.
REQ-019 RUN: the session ends when fl_nstate==3'b000 and fl_lamp==0 in the same cycle; go to DONE.
REQ-020 DONE: done[granted] = 1 for one cycle, flick=0, gnt cleared, ptr = (granted+1) mod N_REQ; go to IDLE.
REQ-021 Arbitration latency: req rises in IDLE at edge k; gnt valid after edge k+1; flick high after edge k+2.
REQ-022 A req deassertion during START or RUN is ignored; the session runs to completion.
REQ-023 req bits asserted during a session are not granted until the next IDLE cycle; the minimum gap between sessions is one IDLE cycle.
REQ-024 All requesters asserted continuously: grants rotate 0,1,2,3,0...
REQ-025 ptr wraps from N_REQ-1 to 0.
REQ-026 flick is 0 in IDLE and DONE.

Reset
REQ-027 With rst_n=1 at an edge: state=IDLE, gnt=0, flick=0, done=0, err=0, ptr=0, watchdog counter=0.
REQ-028 Reset mid-session drops gnt and flick at that edge; no done pulse is issued.

Configuration
REQ-029 Macro FLASH_ARB_TMO_EN defined: an 8-bit or wider counter clears on START and increments each RUN cycle.
REQ-030 When the counter reaches TMO_CYC with no end condition: err is set (sticky until reset), and the FSM goes to DONE with the normal done pulse and ptr advance.
REQ-031 Macro undefined: no counter is present, err is tied to 0, and RUN waits indefinitely.

Structure
REQ-032 Shared package flash_pkg holds: the FSM state enum, the flasher INIT encoding 3'b000, and defaults for N_REQ and MX_LP.
REQ-033 One sub-module, flash_rr_pick: combinational round-robin picker taking req and ptr, returning a one-hot pick and its index.

Verification
REQ-034 Single requester, req[2]=1 for one cycle, ext=0, connected to the flasher: gnt=4'b0100 for the full bounce (0-15, 15-5, 5-10, 10-0, 0-5, 5-0); done[2] pulses once after the end condition; ptr=3.
REQ-035 req=4'b1111 held: grant order 0,1,2,3,0, with exactly one IDLE cycle between sessions.
REQ-036 Granted requester 1 holds ext[1]=1 while lamps fall through lamp 5 in 15-5: the flasher restarts 0-15, flick follows ext with one-cycle delay, and the session still ends with done[1].
REQ-037 FLASH_ARB_TMO_EN with TMO_CYC=20, fl_nstate forced to 3'b001: err=1 on cycle 20 of RUN, done pulses, IDLE follows, and err stays 1 until reset.
REQ-038 rst_n=1 in the middle of RUN: the next cycle shows gnt=0, flick=0, busy=0 and no done pulse; a new req is granted normally afterwards.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and defaults for the flasher arbiter: FSM state encoding,
// flasher INIT encoding and parameter defaults.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [2:0] FL_INIT   = 3'b000;
    localparam int         N_REQ_DEF = 4;
    localparam int         MX_LP_DEF = 16;

    // Index width for N requesters; a single requester still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping, returned as a one-hot vector plus its index.
module flash_rr_pick
    import flash_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam int SW = PTR_W + 1;

    always_comb begin
        logic [SW-1:0]    s;
        logic [PTR_W-1:0] j;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        s    = '0;
        j    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit keeps ptr+i from overflowing before the wrap.
            s = {1'b0, ptr} + SW'(i);
            if (s >= SW'(N_REQ))
                s = s - SW'(N_REQ);
            j = s[PTR_W-1:0];
            if (!any && req[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/flash_arb.sv
// Round-robin arbiter granting one requester at a time the shared flasher.
// Optional session watchdog enabled by defining FLASH_ARB_TMO_EN.
module flash_arb
    import flash_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MX_LP   = MX_LP_DEF,
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] ext,
    input  logic [MX_LP-1:0] fl_lamp,
    input  logic [2:0]       fl_nstate,
    output logic             flick,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             err
);

    localparam int PTR_W = ptr_w(N_REQ);

    arb_state_t       state, state_d;
    logic [PTR_W-1:0] ptr, gidx, pick_idx;
    logic [N_REQ-1:0] pick;
    logic             pick_any;
    logic             flick_d;
    logic             fl_end;
    logic             tmo;

    flash_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign fl_end = (fl_nstate == FL_INIT) && (fl_lamp == '0);

`ifdef FLASH_ARB_TMO_EN
    localparam int CNT_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    // Fires on the TMO_CYC-th RUN cycle, i.e. as the count reaches TMO_CYC.
    assign tmo = (state == RUN) && !fl_end && (cnt == CNT_W'(TMO_CYC - 1));
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == START)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + CNT_W'(1);
            if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        flick_d = 1'b0;
        case (state)
            IDLE:    if (pick_any) state_d = START;
            START: begin
                state_d = RUN;
                flick_d = 1'b1;
            end
            RUN: begin
                if (fl_end || tmo)
                    state_d = DONE;
                else
                    flick_d = ext[gidx];
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            flick <= 1'b0;
            gnt   <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            flick <= flick_d;
            if (state == IDLE && pick_any) begin
                gnt  <= pick;
                gidx <= pick_idx;
            end else if (state == DONE) begin
                gnt <= '0;
                ptr <= (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
            end
        end
    end

    // done is a decode of DONE, so a reset mid-session can never pulse it.
    assign done = (state == DONE) ? gnt : '0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_flash_arb.sv
// Directed bench for flash_arb with a behavioural flasher bouncing
// 0-15, 15-5, 5-10, 10-0, 0-5, 5-0 (kickback while falling toward lamp 5).
module tb_flash_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  ext = '0;
    logic [15:0] fl_lamp;
    logic [2:0]  fl_nstate;
    logic        flick;
    logic [3:0]  gnt, done;
    logic        busy, err;

    logic force_ns = 1'b0;
    int   fs = 0, c = 0, ns, nc;
    int   pass = 0, total = 0;

    always #5 clk = ~clk;

    flash_arb #(.N_REQ(4), .MX_LP(16), .TMO_CYC(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ext       (ext),
        .fl_lamp   (fl_lamp),
        .fl_nstate (fl_nstate),
        .flick     (flick),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    // Flasher model: fs = phase (0 = INIT), c = number of lit lamps.
    always_comb begin
        ns = fs;
        nc = c;
        case (fs)
            0: if (flick) begin ns = 1; nc = 0; end
            1: if (c == 16) ns = 2; else nc = c + 1;
            2: if (flick && c <= 6) begin ns = 1; nc = 0; end
               else if (c == 5) ns = 3; else nc = c - 1;
            3: if (c == 10) ns = 4; else nc = c + 1;
            4: if (c == 0) ns = 5; else nc = c - 1;
            5: if (c == 5) ns = 6; else nc = c + 1;
            6: if (c == 0) ns = 0; else nc = c - 1;
            default: ns = 0;
        endcase
    end

    assign fl_nstate = force_ns ? 3'b001 : 3'(ns);
    assign fl_lamp   = 16'((32'd1 << c) - 32'd1);

    always @(posedge clk) begin
        if (rst_n) begin
            fs <= 0;
            c  <= 0;
        end else begin
            fs <= ns;
            c  <= nc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until a done pulse; reports cycles taken, whether gnt stayed put, and done.
    task automatic wait_done(input logic [3:0] exp_gnt, output int ncyc,
                             output logic held, output logic [3:0] dval);
        ncyc = -1;
        held = 1'b1;
        dval = '0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done !== 4'b0000) begin
                ncyc = i + 1;
                dval = done;
                break;
            end
            if (gnt !== exp_gnt) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = '0; ext = '0;
        step(); step();
        total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else pass++;
        total++; if (flick !== 1'b0) $display("FAIL reset_flick got=%b exp=0", flick); else pass++;
        total++; if (done !== 4'b0000) $display("FAIL reset_done got=%b exp=0000", done); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass++;
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_single();
        int nc_; logic held; logic [3:0] dv;
        req = 4'b0100;
        step();
        req = '0;
        total++; if (gnt !== 4'b0100) $display("FAIL single_gnt got=%b exp=0100", gnt); else pass++;
        total++; if ({busy, flick} !== 2'b10) $display("FAIL single_start got=%b exp=10", {busy, flick}); else pass++;
        step();
        total++; if (flick !== 1'b1) $display("FAIL single_flick_lat got=%b exp=1", flick); else pass++;
        wait_done(4'b0100, nc_, held, dv);
        total++; if (nc_ !== 59) $display("FAIL single_len got=%0d exp=59", nc_); else pass++;
        total++; if (held !== 1'b1) $display("FAIL single_gnt_held got=%b exp=1", held); else pass++;
        total++; if ({dv, flick} !== 5'b0100_0) $display("FAIL single_done got=%b exp=01000", {dv, flick}); else pass++;
        step();
        total++; if ({gnt, done, busy} !== 9'b0) $display("FAIL single_idle got=%b exp=000000000", {gnt, done, busy}); else pass++;
    endtask

    // After the session of requester 2, ptr is 3: bit 3 must win over 0 and 1.
    task automatic test_ptr();
        int nc_; logic held; logic [3:0] dv;
        req = 4'b1011;
        step();
        req = '0;
        total++; if (gnt !== 4'b1000) $display("FAIL ptr3_gnt got=%b exp=1000", gnt); else pass++;
        wait_done(4'b1000, nc_, held, dv);
        total++; if (dv !== 4'b1000) $display("FAIL ptr3_done got=%b exp=1000", dv); else pass++;
        step();
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int nc_; logic held; logic [3:0] dv;
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            step();
            total++; if (gnt !== exp_g[s]) $display("FAIL rot%0d_gnt got=%b exp=%b", s, gnt, exp_g[s]); else pass++;
            wait_done(exp_g[s], nc_, held, dv);
            if (s == 4) req = '0;
            total++; if ({dv, held} !== {exp_g[s], 1'b1}) $display("FAIL rot%0d_done got=%b exp=%b1", s, {dv, held}, exp_g[s]); else pass++;
            total++; if (nc_ !== 60) $display("FAIL rot%0d_len got=%0d exp=60", s, nc_); else pass++;
            step();
            total++; if ({busy, gnt} !== 5'b0) $display("FAIL rot%0d_gap got=%b exp=00000", s, {busy, gnt}); else pass++;
        end
    endtask

    task automatic test_kick();
        logic prev, kicked, seen;
        int   flick_bad;
        req = 4'b0010;
        step();
        req = '0;
        total++; if (gnt !== 4'b0010) $display("FAIL kick_gnt got=%b exp=0010", gnt); else pass++;
        step();
        kicked = 1'b0; seen = 1'b0; flick_bad = 0;
        for (int i = 0; i < 400; i++) begin
            prev = ext[1];
            step();
            if (done !== 4'b0000) begin seen = 1'b1; break; end
            if (flick !== prev) flick_bad++;
            if (!kicked && !ext[1] && fs == 2 && c == 8) ext = 4'b0010;
            else if (ext[1] && fs == 1) begin kicked = 1'b1; ext = '0; end
        end
        total++; if (kicked !== 1'b1) $display("FAIL kick_restart got=%b exp=1", kicked); else pass++;
        total++; if (flick_bad != 0) $display("FAIL kick_flick_delay got=%0d exp=0 bad cycles", flick_bad); else pass++;
        total++; if ({seen, done} !== 5'b1_0010) $display("FAIL kick_done got=%b exp=10010", {seen, done}); else pass++;
        step();
    endtask

    task automatic test_reset_mid();
        int nc_; logic held; logic [3:0] dv;
        req = 4'b0001;
        step();
        req = '0;
        total++; if (gnt !== 4'b0001) $display("FAIL wrap_gnt got=%b exp=0001", gnt); else pass++;
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        total++; if ({gnt, flick, busy, done} !== 10'b0) $display("FAIL midrst got=%b exp=0000000000", {gnt, flick, busy, done}); else pass++;
        req = 4'b0110;
        step();
        req = '0;
        total++; if (gnt !== 4'b0010) $display("FAIL midrst_regnt got=%b exp=0010", gnt); else pass++;
        wait_done(4'b0010, nc_, held, dv);
        total++; if ({dv, nc_[7:0]} !== {4'b0010, 8'd60}) $display("FAIL midrst_done got=%b/%0d exp=0010/60", dv, nc_); else pass++;
        step();
    endtask

    task automatic test_timeout();
        int early;
        req = 4'b0001;
        force_ns = 1'b1;
        step();
        req = '0;
        step();
`ifdef FLASH_ARB_TMO_EN
        early = 0;
        for (int i = 2; i <= 20; i++) begin
            step();
            if (err !== 1'b0 || done !== 4'b0000) early++;
        end
        total++; if (early != 0) $display("FAIL tmo_early got=%0d exp=0 bad cycles", early); else pass++;
        step();
        total++; if ({err, done} !== 5'b1_0001) $display("FAIL tmo_fire got=%b exp=10001", {err, done}); else pass++;
        step();
        total++; if ({busy, err} !== 2'b01) $display("FAIL tmo_idle got=%b exp=01", {busy, err}); else pass++;
        force_ns = 1'b0;
        for (int i = 0; i < 200 && fs != 0; i++) step();
        step();
        total++; if ({busy, err} !== 2'b01) $display("FAIL tmo_sticky got=%b exp=01", {busy, err}); else pass++;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        total++; if (err !== 1'b0) $display("FAIL tmo_clear got=%b exp=0", err); else pass++;
`else
        early = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy !== 1'b1 || err !== 1'b0 || done !== 4'b0000) early++;
        end
        total++; if (early != 0) $display("FAIL notmo_wait got=%0d exp=0 bad cycles", early); else pass++;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        force_ns = 1'b0;
        total++; if ({busy, err} !== 2'b00) $display("FAIL notmo_rst got=%b exp=00", {busy, err}); else pass++;
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ptr();
        test_rotate();
        test_kick();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
